// File: rtl/spi_reg_controller.sv
// spi_reg_controller: byte-level command decoder between an SPI byte reader
// and an 8-bit register file.
//
// Frame format (one byte per rx_valid pulse):
//   0x01 <addr> <data>...   write stream, address auto-increments
//   0x02 <addr> <any>...    read stream, tx_data reloaded per byte
//   0x00                    no-op, stays idle
//   other                   sets sticky err, remaining bytes discarded
//
// Build option: define SPI_REG_CTRL_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES idle clocks between bytes. Without it, frames stream
// indefinitely and a discarded frame is left only through reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_data    received byte
//   rx_valid   one-clk qualifier for rx_data
//   tx_data    byte for the reader's next transfer
//   reg_addr   register-file address
//   reg_wdata  register write data
//   reg_we     one-clk write strobe
//   reg_rdata  combinational read data at reg_addr
//   busy       high whenever a frame is in progress
//   err        sticky unknown-command flag

module spi_reg_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 16;

    localparam logic [BYTE_W-1:0] CMD_NOP   = 8'h00;
    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

    // Reject out-of-range timeouts at elaboration
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("spi_reg_controller: TIMEOUT_CYCLES must be in 2..65535");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_DISCARD
    } state_t;

    state_t state, state_next;
    logic   mode_rd, mode_rd_next;   // latched command: 1 = read frame
    logic   timeout;

    logic              rd_pend, rd_pend_next;   // load tx_data next cycle
    logic [BYTE_W-1:0] tx_next, addr_next, wdata_next;
    logic              we_next, busy_next, err_next;

    logic cmd_unknown;
    assign cmd_unknown = (rx_data != CMD_NOP) && (rx_data != CMD_WRITE) &&
                         (rx_data != CMD_READ);

`ifdef SPI_REG_CTRL_TIMEOUT_EN
    // Idle-gap counter: cleared by every byte, runs only inside a frame
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (rx_valid || state == S_IDLE || timeout) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th silent cycle; a coincident byte wins
    assign timeout = (state != S_IDLE) && !rx_valid &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            mode_rd <= 1'b0;
        end else begin
            state   <= state_next;
            mode_rd <= mode_rd_next;
        end
    end

    // Next-state logic: advances only on received bytes, or on timeout
    always_comb begin
        state_next   = state;
        mode_rd_next = mode_rd;
        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (rx_data == CMD_WRITE) begin
                        state_next   = S_ADDR;
                        mode_rd_next = 1'b0;
                    end else if (rx_data == CMD_READ) begin
                        state_next   = S_ADDR;
                        mode_rd_next = 1'b1;
                    end else if (cmd_unknown) begin
                        state_next = S_DISCARD;
                    end
                end
                S_ADDR:  state_next = mode_rd ? S_READ : S_WRITE;
                default: state_next = state;
            endcase
        end else if (timeout) begin
            state_next = S_IDLE;
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        tx_next      = tx_data;
        addr_next    = reg_addr;
        wdata_next   = reg_wdata;
        we_next      = 1'b0;
        rd_pend_next = 1'b0;
        err_next     = err;
        busy_next    = (state_next != S_IDLE);

        // Address advances the cycle after a write strobe or a read load
        if (reg_we || rd_pend) begin
            addr_next = reg_addr + BYTE_W'(1);
        end
        if (rd_pend) begin
            tx_next = reg_rdata;
        end

        if (rx_valid) begin
            case (state)
                S_IDLE: begin
                    if (cmd_unknown) begin
                        err_next = 1'b1;
                    end
                end
                S_ADDR: begin
                    addr_next    = rx_data;
                    rd_pend_next = mode_rd;
                end
                S_WRITE: begin
                    wdata_next = rx_data;
                    we_next    = 1'b1;
                end
                S_READ: begin
                    rd_pend_next = 1'b1;
                end
                default: ;
            endcase
        end else if (timeout) begin
            tx_next = '0;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data   <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            rd_pend   <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_data   <= tx_next;
            reg_addr  <= addr_next;
            reg_wdata <= wdata_next;
            reg_we    <= we_next;
            rd_pend   <= rd_pend_next;
            busy      <= busy_next;
            err       <= err_next;
        end
    end

endmodule

// File: tb/tb_spi_reg_controller.sv
// Testbench for spi_reg_controller: directed frames plus random frames,
// checked through expectation queues drained by a negedge monitor.

module tb_spi_reg_controller;

    localparam int unsigned TMO = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       err;

    logic [7:0] regs [256];
    assign reg_rdata = regs[reg_addr];

    spi_reg_controller #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expectation queues
    typedef struct { int cyc; logic [7:0] val; } tx_exp_t;
    typedef struct { int cyc; logic busy; logic err; } st_exp_t;
    typedef struct { logic [7:0] addr; logic [7:0] data; } wr_exp_t;

    tx_exp_t tx_q[$];
    st_exp_t st_q[$];
    wr_exp_t wr_q[$];

    // Reference model: frame decoder in plain procedural terms
    localparam int M_IDLE = 0, M_ADDR = 1, M_WRITE = 2, M_READ = 3, M_DISC = 4;
    int         m_state = M_IDLE;
    bit         m_rd    = 1'b0;
    bit         m_err   = 1'b0;
    logic [7:0] m_addr  = 8'h00;
    int         last_n  = 0;

    task automatic model_byte(input logic [7:0] b, input int n);
        case (m_state)
            M_IDLE: begin
                if (b == 8'h01)      begin m_state = M_ADDR; m_rd = 1'b0; end
                else if (b == 8'h02) begin m_state = M_ADDR; m_rd = 1'b1; end
                else if (b != 8'h00) begin m_state = M_DISC; m_err = 1'b1; end
            end
            M_ADDR: begin
                m_addr = b;
                if (m_rd) begin
                    m_state = M_READ;
                    tx_q.push_back('{n + 2, regs[m_addr]});
                    m_addr = m_addr + 8'd1;
                end else begin
                    m_state = M_WRITE;
                end
            end
            M_WRITE: begin
                wr_q.push_back('{m_addr, b});
                m_addr = m_addr + 8'd1;
            end
            M_READ: begin
                tx_q.push_back('{n + 2, regs[m_addr]});
                m_addr = m_addr + 8'd1;
            end
            default: ;
        endcase
        st_q.push_back('{n + 1, m_state != M_IDLE, m_err});
    endtask

    // One byte, then hold rx_valid low so pulses are 'gap' cycles apart
    task automatic send(input logic [7:0] b, input int gap);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        last_n   = cyc;
        model_byte(b, cyc);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap - 2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        tx_q.push_back('{cyc, 8'h00});
        st_q.push_back('{cyc, 1'b0, 1'b0});
        @(negedge clk);
        chk("rst_addr", 32'(reg_addr), 32'h0);
        chk("rst_wdata", 32'(reg_wdata), 32'h0);
        chk("rst_we", 32'(reg_we), 32'h0);
        @(posedge clk); #1;
        rst     = 1'b1;
        m_state = M_IDLE;
        m_rd    = 1'b0;
        m_err   = 1'b0;
        m_addr  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: tx_data held against the latest expected value every cycle
    logic [7:0] tx_hold = 8'h00;
    always @(negedge clk) begin
        while (tx_q.size() > 0 && tx_q[0].cyc <= cyc) begin
            tx_hold = tx_q[0].val;
            void'(tx_q.pop_front());
        end
        chk("tx_data", 32'(tx_data), 32'(tx_hold));

        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            chk("busy", 32'(busy), 32'(st_q[0].busy));
            chk("err", 32'(err), 32'(st_q[0].err));
            void'(st_q.pop_front());
        end

        if (reg_we === 1'b1) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_we", 32'(reg_we), 32'h0);
            end else begin
                chk("we_addr", 32'(reg_addr), 32'(wr_q[0].addr));
                chk("we_data", 32'(reg_wdata), 32'(wr_q[0].data));
                void'(wr_q.pop_front());
            end
        end
    end

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
        regs[8'h20] = 8'h5A;
        regs[8'h21] = 8'h3C;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        do_reset();

        // Two-byte write stream with wide gaps
        send(8'h01, 20); send(8'h10, 20); send(8'hAB, 20); send(8'hCD, 20);
        do_reset();

        // Read stream from known registers
        send(8'h02, 5); send(8'h20, 5); send(8'h00, 5);
        do_reset();

        // Write address wrap
        send(8'h01, 4); send(8'hFF, 4); send(8'h11, 4); send(8'h22, 4);
        do_reset();

        // Read address wrap
        send(8'h02, 4); send(8'hFF, 4); send(8'h33, 4);
        do_reset();

        // Reset between address and data of a write, then a read
        send(8'h01, 6); send(8'h40, 6);
        do_reset();
        send(8'h02, 5); send(8'h21, 5); send(8'h99, 5);
        do_reset();

        // Unknown command: sticky err, discard
        send(8'h7E, 3);
`ifdef SPI_REG_CTRL_TIMEOUT_EN
        st_q.push_back('{last_n + 45, 1'b1, 1'b1});
        st_q.push_back('{last_n + 60, 1'b0, 1'b1});
        repeat (70) @(posedge clk);
        #1;
        m_state = M_IDLE;
        send(8'h00, 5);
        send(8'h7E, 5);
`else
        st_q.push_back('{last_n + 90, 1'b1, 1'b1});
        repeat (100) @(posedge clk);
        #1;
        send(8'h01, 4); send(8'h55, 4); send(8'h66, 4); send(8'h7E, 4);
`endif
        do_reset();

        // Random frames
        for (int f = 0; f < 20; f++) begin
            int kind;
            int nbytes;
            kind   = $urandom_range(0, 2);
            nbytes = $urandom_range(1, 5);
            if (kind == 2) send(8'h00, $urandom_range(3, 8));
            send((kind == 0) ? 8'h01 : 8'h02, $urandom_range(3, 12));
            send(8'($urandom), $urandom_range(3, 12));
            for (int b = 0; b < nbytes; b++) begin
                send(8'($urandom), $urandom_range(3, 12));
            end
            do_reset();
        end

        repeat (5) @(posedge clk);
        @(negedge clk); #1;
        chk("wr_q_left", 32'(wr_q.size()), 32'h0);
        chk("tx_q_left", 32'(tx_q.size()), 32'h0);
        chk("st_q_left", 32'(st_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
